// File: rtl/register_file_mp.sv
// Multi-port register file with two write ports, N_RD combinational read ports,
// optional write-to-read bypass and a per-register pending scoreboard.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_ena0,
  input  logic [ADDR_W-1:0]        wr_addr0,
  input  logic [DATA_W-1:0]        wr_data0,
  input  logic                     wr_ena1,
  input  logic [ADDR_W-1:0]        wr_addr1,
  input  logic [DATA_W-1:0]        wr_data1,
  input  logic                     rsv_ena,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_busy,
  output logic                     collide
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic              collide_q, collide_d;
  logic              wr_vld0, wr_vld1, rsv_vld;

  // Register 0 is never a legal target when it is hardwired to zero.
  assign wr_vld0 = wr_ena0 && !((ZERO_REG != 0) && (wr_addr0 == '0));
  assign wr_vld1 = wr_ena1 && !((ZERO_REG != 0) && (wr_addr1 == '0));
  assign rsv_vld = rsv_ena && !((ZERO_REG != 0) && (rsv_addr == '0));

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    pending_d = pending_q;
    if (wr_vld0) pending_d[wr_addr0] = 1'b0;
    if (wr_vld1) pending_d[wr_addr1] = 1'b0;
    if (rsv_vld) pending_d[rsv_addr] = 1'b1;
    collide_d = wr_vld0 && wr_vld1 && (wr_addr0 == wr_addr1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this storage must read as zero straight out of reset, so it is reset like
      // ordinary flops rather than left to power-up state as a RAM would be.
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pending_q <= '0;
      collide_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments to the same element resolve to the last one
      // executed, which gives write port 1 priority on an address collision.
      if (wr_vld0) regs_q[wr_addr0] <= wr_data0;
      if (wr_vld1) regs_q[wr_addr1] <= wr_data1;
      pending_q <= pending_d;
      collide_q <= collide_d;
    end
  end

  assign collide = collide_q;

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = regs_q[addr];
      busy = pending_q[addr];
      // Bypass is suppressed in reset so reads stay zero while rst is held.
      if ((BYPASS != 0) && !rst) begin
        if (wr_vld1 && (wr_addr1 == addr)) begin
          data = wr_data1;
          busy = rsv_vld && (rsv_addr == addr);
        end else if (wr_vld0 && (wr_addr0 == addr)) begin
          data = wr_data0;
          busy = rsv_vld && (rsv_addr == addr);
        end
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = busy;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the 2-read/1-write register file: configurable width, depth and read-port count, plus a second write port.
- Adds optional write-to-read bypass and a per-register pending (scoreboard) bit used by the pipeline to stall on in-flight producers.
- Sits in the CPU decode/writeback boundary; decode reads operands and busy flags, issue reserves destinations, writeback ports clear them.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
N_RD, 2, number of read ports (1..8)
BYPASS, 1, 1 = same-cycle write data/clear visible on reads; 0 = reads show stored state only
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
wr_ena0  input  1  write port 0 enable
wr_addr0  input  ADDR_W  write port 0 address
wr_data0  input  DATA_W  write port 0 data
wr_ena1  input  1  write port 1 enable (priority over port 0)
wr_addr1  input  ADDR_W  write port 1 address
wr_data1  input  DATA_W  write port 1 data
rsv_ena  input  1  reserve request: set pending bit of rsv_addr
rsv_addr  input  ADDR_W  register to reserve
rd_addr  input  N_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  output  N_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W]
rd_busy  output  N_RD  pending flag for each read address
collide  output  1  registered; 1 for the cycle after both write ports targeted the same valid address

Behaviour:
- Reset (rst=1, asynchronous, independent of clk): all registers = 0, all pending bits = 0, collide = 0. rd_data therefore reads 0 and rd_busy reads 0 while rst is held and after release. Reset mid-operation discards any write or reserve in that cycle.
- Writes: on posedge, if wr_enaN and not (ZERO_REG and wr_addrN==0), reg[wr_addrN] <= wr_dataN. If both ports enabled with equal address, port 1 value stored; collide <= 1 next cycle, else collide <= 0. With ZERO_REG, writes to addr 0 are dropped and do not set collide.
- Pending bits: on posedge, a valid write to address A clears pending[A]; rsv_ena sets pending[rsv_addr]. Reserve and write to the same address in the same cycle: reserve wins (pending = 1, data still written). With ZERO_REG, reserve of addr 0 ignored.
- Reads: combinational, zero cycle latency, all N_RD ports independent, any ports may share an address.
  - BYPASS=0: rd_data = reg[rd_addr], rd_busy = pending[rd_addr].
  - BYPASS=1: if a valid write to rd_addr is active this cycle, rd_data = that write data (port 1 over port 0) and rd_busy = 0 unless rsv_ena targets the same address this cycle (then 1); else stored values.
  - ZERO_REG and rd_addr==0: rd_data = 0, rd_busy = 0 in all cases.
- No handshake back-pressure: every enabled write/reserve completes in one cycle.
- Width rules: no arithmetic; data stored and returned bit-exact. Addresses always in range (DEPTH = 2**ADDR_W).

Test Plan:
- Fill/readback (N_RD=4): write -(i+1) to i=0..31 via port 0, then read addr i, 31-i, (i+7)%32, (i+13)%32 -> each shows -(i+1) for its address; addr 0 reads 0x00000000 on all ports.
- Dual-write collision: wr_ena0=wr_ena1=1, both addr 5, data 0x11111111 / 0x22222222 -> reg5 = 0x22222222, collide = 1 for one cycle then 0; different addresses (5, 6) -> both stored, collide = 0.
- Bypass: BYPASS=1, write 0xDEADBEEF to addr 9 while rd_addr port0 = 9 -> rd_data0 = 0xDEADBEEF same cycle; BYPASS=0 -> old value that cycle, 0xDEADBEEF next cycle.
- Scoreboard: rsv addr 12 -> rd_busy=1 next cycle; write addr 12 -> busy 0 (same cycle if BYPASS=1, next if 0); simultaneous rsv+write addr 12 -> busy stays 1, data updated; rsv addr 0 -> busy stays 0.
- Async reset: mid-sequence with regs nonzero and pending bits set, pulse rst between clock edges -> rd_data and rd_busy go to 0 immediately without a clock edge, collide = 0; a write enabled in the reset cycle is not stored.
